// File: rtl/asiclab_pkg.sv
// Shared definitions for the nibble adder and sum accumulator stages.
// Keeps the state encoding and default widths in one place so both stages agree.
package asiclab_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } acc_state_t;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ACC_W  = 8;
  localparam int DEF_COUNT  = 4;

  // Counter width for a modulo-count range; never narrower than one bit.
  function automatic int cnt_w(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/sum_accumulator_if.sv
// Sample-in / total-out handshake bundle for the sum accumulator.
// Master drives samples, clear and out_ready; slave returns ready, total and overflow.
interface sum_accumulator_if #(
  parameter int DATA_W = asiclab_pkg::DEF_DATA_W,
  parameter int ACC_W  = asiclab_pkg::DEF_ACC_W
);
  logic              clear;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [ACC_W-1:0]  out_data;
  logic              out_overflow;
  logic              out_ready;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_overflow
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_overflow
  );
endinterface

// File: rtl/sum_accumulator_batch_counter.sv
// Modulo-COUNT sample counter with enable, synchronous clear and terminal-count flag.
// Single-cycle update; tc is decoded from the count register only.
module batch_counter
  import asiclab_pkg::*;
#(
  parameter int COUNT = DEF_COUNT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tc
);
  localparam int CNT_W = cnt_w(COUNT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == CNT_W'(COUNT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates COUNT samples into a wrapping ACC_W total with sticky carry flag; 1-cycle accept latency.
// Holds the total with in_ready=0 until out_ready; ready/valid decode from state only.
module sum_accumulator
  import asiclab_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int COUNT  = DEF_COUNT
) (
  input  logic               clk,
  input  logic               reset,
  sum_accumulator_if.slave   bus
);
  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;
  logic             accept;
  logic             out_hs;
  logic             tc;

  assign accept = bus.in_valid & (state_q == ST_ACCUM) & ~bus.clear;
  assign out_hs = bus.out_ready & (state_q == ST_DONE) & ~bus.clear;
  assign sum    = {1'b0, acc_q} + (ACC_W + 1)'(bus.in_data);

  batch_counter #(.COUNT(COUNT)) u_batch_counter (
    .clk   (clk),
    .reset (reset),
    .en    (accept),
    .clr   (bus.clear | out_hs),
    .tc    (tc)
  );

  // clear outranks both the sample accept and the output handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (bus.clear) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      acc_d = sum[ACC_W-1:0];
      ovf_d = ovf_q | sum[ACC_W];
      if (tc) begin
        state_d = ST_DONE;
      end
    end else if (out_hs) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready     = (state_q == ST_ACCUM);
  assign bus.out_valid    = (state_q == ST_DONE);
  assign bus.out_data     = acc_q;
  assign bus.out_overflow = ovf_q;

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the nibble adder's 4-bit sum stream. It accepts sum samples over a valid/ready handshake and accumulates a fixed-size batch of samples into a wider running total. When the batch is complete it presents the total and a sticky overflow flag on an output valid/ready handshake, then holds until the total is taken.

## Interface
- DATA_W, 4, width of each incoming sum sample
- ACC_W, 8, accumulator/result width; the total wraps modulo 2^ACC_W
- COUNT, 4, samples per batch; legal range ≥1
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- clear  input  1  synchronous batch abort; returns to empty ACCUM state
- in_valid  input  1  upstream sample valid
- in_data  input  DATA_W  sum sample from the adder stage, unsigned
- in_ready  output  1  block can take a sample
- out_valid  output  1  batch total available
- out_data  output  ACC_W  accumulator register; meaningful when out_valid=1
- out_overflow  output  1  sticky flag: some add in this batch carried out of ACC_W
- out_ready  input  1  downstream takes the total

## Operation
- FSM, two states:
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept condition: in_valid & in_ready & ~clear.
  - On accept, do the (ACC_W+1)-bit sum acc + zero-extended in_data.
  - acc takes the low ACC_W bits.
  - overflow |= carry bit.
  - cnt increments.
- Batch end: an accept with cnt==COUNT-1 moves the FSM ACCUM→DONE. cnt is not incremented past COUNT-1; it is cleared to 0 on the transition.
- Output handshake: out_valid & out_ready in DONE moves the FSM DONE→ACCUM and clears acc=0, overflow=0, cnt=0.
- In DONE, in_valid is ignored. No sample is consumed or lost, because in_ready=0.
- clear=1: next state ACCUM; acc, cnt and overflow go to 0.
  - clear takes priority over an accept in the same cycle; that sample is dropped and counts as not accepted.
  - clear also takes priority over an output handshake in the same cycle.
- in_ready and out_valid are decoded directly from the state register. No combinational path from in_valid or out_ready to any output.
- out_data = acc and out_overflow = overflow at all times. Outside DONE they show the partial batch.
- reset (async): state=ACCUM, acc=0, cnt=0, overflow=0. Output values: in_ready=1, out_valid=0, out_data=0, out_overflow=0.

## Timing
- Accept latency: a sample accepted at edge N is visible in out_data after edge N.
- Batch latency: out_valid rises on the edge that accepts sample COUNT. The final total is valid in the same cycle that out_valid is first high.
- DONE lasts at least 1 cycle. out_valid, out_data and out_overflow are held stable until the output handshake.
- Minimum batch period: COUNT+1 cycles (COUNT accepts plus one DONE cycle with out_ready=1).
- After the output handshake at edge M, in_ready=1 and out_data=0 from edge M onward.
- Reset asserted mid-batch: all state clears immediately, independent of clk. The partial batch is discarded.
- COUNT=1: every accept goes straight to DONE.

## Structure
- Shared package (asiclab_pkg), holding:
  - state encoding ST_ACCUM=1'b0, ST_DONE=1'b1;
  - default DATA_W/ACC_W/COUNT localparams, so that the adder stage and this block agree on DATA_W.
- cnt width: $clog2(COUNT), minimum 1 bit.
- Natural sub-module: batch_counter, a modulo-COUNT counter with enable, synchronous clear and a terminal-count output (cnt==COUNT-1). The top level holds the FSM, accumulator and overflow flag.

## Test plan
- Reset: assert reset mid-batch after 2 accepts → out_valid=0, out_data=0, out_overflow=0, in_ready=1 immediately. The next batch needs 4 fresh samples.
- Basic batch (defaults): in_data 3,5,7,9 with in_valid=1 on consecutive cycles, out_ready=1 → out_valid high for exactly 1 cycle, with out_data=24 and out_overflow=0. in_ready=0 in that cycle, and in_ready=1 on the next.
- Backpressure: same batch with out_ready=0 for 5 cycles and in_valid=1 throughout → out_valid/out_data=24 held and in_ready=0 for all 5 cycles. With out_ready=1 → next cycle out_data=0, in_ready=1.
- Overflow (ACC_W=6, COUNT=8): eight samples of 15 → out_data=120 mod 64=56, out_overflow=1. The flag clears after the output handshake.
- Gapped input: in_valid pattern 1,0,0,1,0,1,1 carrying 1,x,x,2,x,4,8 → only the valid samples count, giving out_data=15 after the 4th valid.
- Clear priority: clear=1 with in_valid=1, in_data=9 after 2 accepts → next cycle acc=0, cnt=0 and the sample is not counted. A following batch of four 1s gives out_data=4.
